mem_access_stage: RTL

//  MEM pipeline stage directly downstream of the EX/MEM register. Issues loads/stores
//  to data memory over a req/gnt/rvalid bus. Generates byte enables and store-data

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid bus and aligns load data.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being force-aligned.
module mem_access_stage #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        mem_err,
   output logic        misalign_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [1:0]  ofs_p1;
   logic [2:0]  f3_p1;
   logic [4:0]  rd_p1;
   logic [31:0] alu_p1;
   logic        reg_write_p1, mem_to_reg_p1;

   logic        is_mem, misaligned, trap, accept_mem, accept_alu;
   logic        stall, done_store, done_load, abort, tmo;
   logic [1:0]  ofs_ex;
   logic [3:0]  be_ex;

   function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] size);
      case (size)
         2'b00:   store_lanes = {4{d[7:0]}};
         2'b01:   store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] ofs,
                                              input logic [2:0] f3);
      logic [31:0] sh;
      sh = d >> {ofs, 3'b000};
      case (f3[1:0])
         2'b00:   load_align = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_align = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: load_align = sh;
      endcase
   endfunction

   // Decode of the EX/MEM instruction; low address bits not legal for the size are dropped.
   always_comb begin
      is_mem     = ex_mem_read | ex_mem_write;
      misaligned = 1'b0;
      ofs_ex     = 2'b00;
      be_ex      = 4'b1111;
      case (ex_funct3[1:0])
         2'b00: begin
            ofs_ex = ex_alu_result[1:0];
            be_ex  = 4'b0001 << ofs_ex;
         end
         2'b01: begin
            misaligned = ex_alu_result[0];
            ofs_ex     = {ex_alu_result[1], 1'b0};
            be_ex      = 4'b0011 << ofs_ex;
         end
         default: misaligned = |ex_alu_result[1:0];
      endcase
`ifdef MISALIGN_TRAP_EN
      trap = (state == IDLE) & ex_valid & is_mem & misaligned;
`else
      trap = 1'b0;
`endif
      accept_mem = (state == IDLE) & ex_valid & is_mem & ~trap;
      accept_alu = (state == IDLE) & ex_valid & ~is_mem;
   end

   assign tmo = (TIMEOUT != 8'd0) && (state != IDLE) && (cnt == TIMEOUT);

   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      dmem_req   = 1'b0;
      done_store = 1'b0;
      done_load  = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: if (accept_mem) begin
            stall     = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (tmo) begin
            abort     = 1'b1;
            state_nxt = IDLE;
         end else begin
            dmem_req = 1'b1;
            if (dmem_gnt && dmem_we) begin
               done_store = 1'b1;
               state_nxt  = IDLE;
            end else begin
               stall = 1'b1;
               if (dmem_gnt) state_nxt = WAIT;
            end
         end
         WAIT: if (tmo) begin
            abort     = 1'b1;
            state_nxt = IDLE;
         end else if (dmem_rvalid) begin
            done_load = 1'b1;
            state_nxt = IDLE;
         end else begin
            stall = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stall is combinational from state; held low while reset is asserted.
   assign mem_stall = stall & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 32'd0;
         dmem_wdata    <= 32'd0;
         dmem_be       <= 4'd0;
         ofs_p1        <= 2'd0;
         f3_p1         <= 3'd0;
         rd_p1         <= 5'd0;
         alu_p1        <= 32'd0;
         reg_write_p1  <= 1'b0;
         mem_to_reg_p1 <= 1'b0;
         wb_valid      <= 1'b0;
         wb_data       <= 32'd0;
         wb_rd         <= 5'd0;
         wb_reg_write  <= 1'b0;
         mem_err       <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
         if (accept_mem) begin
            dmem_we       <= ex_mem_write;
            dmem_addr     <= {ex_alu_result[31:2], 2'b00};
            dmem_wdata    <= store_lanes(ex_rs2_data, ex_funct3[1:0]);
            dmem_be       <= be_ex;
            ofs_p1        <= ofs_ex;
            f3_p1         <= ex_funct3;
            rd_p1         <= ex_rd;
            alu_p1        <= ex_alu_result;
            reg_write_p1  <= ex_reg_write;
            mem_to_reg_p1 <= ex_mem_to_reg;
         end
         // Result register to MEM/WB: one strobe per completed instruction.
         wb_valid     <= accept_alu | trap | done_store | done_load | abort;
         mem_err      <= abort;
         misalign_o   <= trap;
         wb_reg_write <= 1'b0;
         if (accept_alu | trap) begin
            wb_data      <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= accept_alu & ex_reg_write;
         end else if (done_load) begin
            wb_data      <= mem_to_reg_p1 ? load_align(dmem_rdata, ofs_p1, f3_p1) : alu_p1;
            wb_rd        <= rd_p1;
            wb_reg_write <= reg_write_p1;
         end else if (done_store | abort) begin
            wb_data <= alu_p1;
            wb_rd   <= rd_p1;
         end
      end
   end

endmodule
